vector_sweep_capture: RTL and testbench

VECTOR_SWEEP_CAPTURE -- requirements
Module: vector_sweep_capture

---
 rtl/vector_sweep_capture.sv | 126 ++++++++++++
 tb/tb_vector_sweep_capture.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sweep_capture.sv
// Sweeps all 16 input vectors through a 4-input logic stage and captures {f,g,h}.
// Optional macro VECTOR_SWEEP_SIGNATURE_EN adds an 8-bit rotate/xor response signature.
module vector_sweep_capture #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       f,
    input  logic       g,
    input  logic       h,
    output logic       busy,
    output logic       done,
    input  logic [3:0] rd_addr,
    output logic [2:0] rd_data
`ifdef VECTOR_SWEEP_SIGNATURE_EN
    ,
    output logic [7:0] signature
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] settle_cnt;
    logic [2:0] mem [16];
    logic       sweep_go;
    logic       cap_we;

    // Abort beats start, so a start that coincides with abort never launches.
    assign sweep_go = (state == IDLE || state == DONE) && start && !abort;
    assign cap_we   = (state == CAPTURE) && !abort;

    assign {a, b, c, d} = idx;
    assign rd_data      = mem[rd_addr];

    // Sweep sequencer: settle each vector, capture, advance, stop at row 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (sweep_go) begin
                        state      <= DRIVE;
                        idx        <= 4'd0;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state      <= IDLE;
                        idx        <= 4'd0;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state      <= IDLE;
                        idx        <= 4'd0;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b0;
                    end else if (idx == 4'd15) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= DRIVE;
                        idx        <= idx + 4'd1;
                        settle_cnt <= 4'd0;
                    end
                end
            endcase
        end
    end

    // Truth-table store, written once per vector in CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 3'b000;
            end
        end else if (cap_we) begin
            mem[idx] <= {f, g, h};
        end
    end

`ifdef VECTOR_SWEEP_SIGNATURE_EN
    // Signature restarts with each sweep and folds in every captured response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= 8'h00;
        end else if (sweep_go) begin
            signature <= 8'h00;
        end else if (cap_we) begin
            signature <= {signature[6:0], signature[7]}
                       ^ {5'b0, f, g, h};
        end
    end
`endif

endmodule

// File: tb/tb_vector_sweep_capture.sv
// Bench for vector_sweep_capture: two instances (SETTLE=1 and 3) with a modelled
// logic stage; expected rows and vectors go through a scoreboard queue.
module tb_vector_sweep_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] mode;

    logic       start1, abort1, a1, b1, c1, d1, f1, g1, h1, busy1, done1;
    logic [3:0] rd_addr1;
    logic [2:0] rd_data1;
    logic       start3, abort3, a3, b3, c3, d3, f3, g3, h3, busy3, done3;
    logic [3:0] rd_addr3;
    logic [2:0] rd_data3;
`ifdef VECTOR_SWEEP_SIGNATURE_EN
    logic [7:0] sig1, sig3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q [$];
    logic [3:0] vec_q [$];
    logic [2:0] exp_mem1 [16];

    // Stage models: 0 -> f=a&b g=c|d h=a^d, 1 -> all zero, 2 -> h=1 only
    function automatic logic [2:0] stage(input logic [1:0] m, input logic [3:0] v);
        logic [2:0] r;
        r = 3'b000;
        case (m)
            2'd0: r = {v[3] & v[2], v[1] | v[0], v[3] ^ v[0]};
            2'd2: r = 3'b001;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sig_model(input logic [1:0] m);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            s = {s[6:0], s[7]} ^ {5'b0, stage(m, 4'(i))};
        end
        return s;
    endfunction

    assign {f1, g1, h1} = stage(mode, {a1, b1, c1, d1});
    assign {f3, g3, h3} = stage(mode, {a3, b3, c3, d3});

    vector_sweep_capture #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .d(d1), .f(f1), .g(g1), .h(h1),
        .busy(busy1), .done(done1), .rd_addr(rd_addr1), .rd_data(rd_data1)
`ifdef VECTOR_SWEEP_SIGNATURE_EN
        , .signature(sig1)
`endif
    );

    vector_sweep_capture #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .a(a3), .b(b3), .c(c3), .d(d3), .f(f3), .g(g3), .h(h3),
        .busy(busy3), .done(done3), .rd_addr(rd_addr3), .rd_data(rd_data3)
`ifdef VECTOR_SWEEP_SIGNATURE_EN
        , .signature(sig3)
`endif
    );

    // Pulse start on u1 and count cycles from first DRIVE cycle to done.
    task automatic run_sweep1(output int cyc);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [2:0] e;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy1, done1, a1, b1, c1, d1} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_u1: got %b want 000000", {busy1, done1, a1, b1, c1, d1});
        end
        n_checks++;
        if ({busy3, done3, a3, b3, c3, d3} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_u3: got %b want 000000", {busy3, done3, a3, b3, c3, d3});
        end
`ifdef VECTOR_SWEEP_SIGNATURE_EN
        n_checks++;
        if (sig1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_sig: got %h want 00", sig1);
        end
`endif
        for (int i = 0; i < 16; i++) exp_q.push_back(3'b000);
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data1 !== e) begin
                n_fail++;
                $display("FAIL reset_row%0d: got %b want %b", i, rd_data1, e);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_truth_table();
        int cyc;
        logic [2:0] e;
        mode = 2'd0;
        run_sweep1(cyc);
        n_checks++;
        if (cyc !== 32) begin
            n_fail++;
            $display("FAIL tt_latency: got %0d want 32", cyc);
        end
        n_checks++;
        if ({busy1, done1, a1, b1, c1, d1} !== 6'b011111) begin
            n_fail++;
            $display("FAIL tt_done_state: got %b want 011111", {busy1, done1, a1, b1, c1, d1});
        end
        for (int i = 0; i < 16; i++) begin
            exp_mem1[i] = stage(2'd0, 4'(i));
            exp_q.push_back(exp_mem1[i]);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data1 !== e) begin
                n_fail++;
                $display("FAIL tt_row%0d: got %b want %b", i, rd_data1, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_settle3();
        int cyc;
        int run;
        logic [3:0] v, last, ev;
        logic [2:0] e;
        mode = 2'd0;
        for (int i = 0; i < 16; i++) vec_q.push_back(4'(i));
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 0;
        last = {a3, b3, c3, d3};
        ev = vec_q.pop_front();
        n_checks++;
        if (last !== ev) begin
            n_fail++;
            $display("FAIL s3_first_vec: got %b want %b", last, ev);
        end
        run = 1;
        while (!done3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            v = {a3, b3, c3, d3};
            if (!done3) begin
                if (v !== last) begin
                    n_checks++;
                    if (run !== 4) begin
                        n_fail++;
                        $display("FAIL s3_hold_%0d: got %0d want 4", last, run);
                    end
                    ev = (vec_q.size() > 0) ? vec_q.pop_front() : 4'hx;
                    n_checks++;
                    if (v !== ev) begin
                        n_fail++;
                        $display("FAIL s3_step: got %b want %b", v, ev);
                    end
                    last = v;
                    run = 1;
                end else begin
                    run++;
                end
            end
        end
        n_checks++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL s3_latency: got %0d want 64", cyc);
        end
        n_checks++;
        if (vec_q.size() !== 0 || run !== 4) begin
            n_fail++;
            $display("FAIL s3_coverage: left %0d run %0d want 0 4", vec_q.size(), run);
        end
        vec_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(stage(2'd0, 4'(i)));
        for (int i = 0; i < 16; i++) begin
            rd_addr3 = 4'(i);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data3 !== e) begin
                n_fail++;
                $display("FAIL s3_row%0d: got %b want %b", i, rd_data3, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int cyc;
        logic [2:0] e;
        mode = 2'd2;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while ({a1, b1, c1, d1} !== 4'd5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if ({a1, b1, c1, d1} !== 4'd5) begin
            n_fail++;
            $display("FAIL abort_reach5: got %b want 0101", {a1, b1, c1, d1});
        end
        @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        n_checks++;
        if ({busy1, done1, a1, b1, c1, d1} !== 6'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got %b want 000000", {busy1, done1, a1, b1, c1, d1});
        end
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stays_idle: got %b want 0", busy1);
        end
        for (int i = 0; i < 5; i++) exp_mem1[i] = stage(2'd2, 4'(i));
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_mem1[i]);
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data1 !== e) begin
                n_fail++;
                $display("FAIL abort_row%0d: got %b want %b", i, rd_data1, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [2:0] e;
        mode = 2'd0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while ({a1, b1, c1, d1} !== 4'd9 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if ({busy1, a1, b1, c1, d1} !== 5'b11001) begin
            n_fail++;
            $display("FAIL rstmid_reach9: got %b want 11001", {busy1, a1, b1, c1, d1});
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy1, done1, a1, b1, c1, d1} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b want 000000", {busy1, done1, a1, b1, c1, d1});
        end
        for (int i = 0; i < 16; i++) begin
            exp_mem1[i] = 3'b000;
            exp_q.push_back(3'b000);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            #0.2;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data1 !== e) begin
                n_fail++;
                $display("FAIL rstmid_row%0d: got %b want %b", i, rd_data1, e);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [2:0] e;
        mode = 2'd0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!done1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0;
        n_checks++;
        if (cyc !== 32) begin
            n_fail++;
            $display("FAIL b2b_held_latency: got %0d want 32", cyc);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy1, done1} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_done_hold: got %b want 01", {busy1, done1});
        end
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n_checks++;
        if ({busy1, done1} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_restart: got %b want 10", {busy1, done1});
        end
        cyc = 0;
        while (!done1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 32) begin
            n_fail++;
            $display("FAIL b2b_done_low: got %0d want 32", cyc);
        end
        for (int i = 0; i < 16; i++) begin
            exp_mem1[i] = stage(2'd0, 4'(i));
            exp_q.push_back(exp_mem1[i]);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data1 !== e) begin
                n_fail++;
                $display("FAIL b2b_row%0d: got %b want %b", i, rd_data1, e);
            end
        end
        @(negedge clk);
    endtask

`ifdef VECTOR_SWEEP_SIGNATURE_EN
    task automatic test_signature();
        int cyc;
        logic [7:0] es;
        mode = 2'd1;
        run_sweep1(cyc);
        n_checks++;
        if (sig1 !== 8'h00) begin
            n_fail++;
            $display("FAIL sig_zero: got %h want 00", sig1);
        end
        mode = 2'd2;
        run_sweep1(cyc);
        es = sig_model(2'd2);
        n_checks++;
        if (sig1 !== es) begin
            n_fail++;
            $display("FAIL sig_h1: got %h want %h", sig1, es);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (sig1 !== es) begin
            n_fail++;
            $display("FAIL sig_hold: got %h want %h", sig1, es);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        mode     = 2'd0;
        start1   = 1'b0;
        abort1   = 1'b0;
        rd_addr1 = 4'd0;
        start3   = 1'b0;
        abort3   = 1'b0;
        rd_addr3 = 4'd0;
        test_reset();
        test_truth_table();
        test_settle3();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef VECTOR_SWEEP_SIGNATURE_EN
        test_signature();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
